// File: rtl/add8u_share_sched.sv
// add8u_share_sched
// Round-robin scheduler that time-shares one combinational 8-bit unsigned
// adder core (9-bit result) among NREQ requesters.
//
// One operation takes three cycles:
//   IDLE  the winning request is accepted and its operands are registered
//         onto core_a/core_b.
//   EXEC  the operands sit stable on the core for a full cycle, and the
//         core result is registered into rsp_sum.
//   RESP  the response is offered to the requester that was served.
// The operand registers are written only when a request is accepted. The
// core inputs therefore do not toggle while the block is idle.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (ready one-hot or 0)
//   req_a/req_b          operands, requester i at bits [8i+7:8i]
//   rsp_valid/rsp_ready  per-requester response handshake (valid one-hot or 0)
//   rsp_sum              9-bit result shared by all requesters
//   core_a/core_b        registered operands driven to the adder core
//   core_o               combinational adder core result
//   busy                 high in EXEC and RESP
//   op_count             saturating count of completed responses
module add8u_share_sched #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [8:0]        rsp_sum,
    output logic [7:0]        core_a,
    output logic [7:0]        core_b,
    input  logic [8:0]        core_o,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [GW-1:0]   last_grant_r;
    logic [GW-1:0]   grant_s;
    logic [GW-1:0]   cand_s;
    logic            grant_found_s;
    logic [7:0]      core_a_r;
    logic [7:0]      core_b_r;
    logic [8:0]      rsp_sum_r;
    logic [CNTW-1:0] op_count_r;
    logic            rsp_accept_s;
    logic [NREQ-1:0] req_ready_s;
    logic [NREQ-1:0] rsp_valid_s;

    // Rotating-priority search. Candidates are walked from the lowest
    // priority (last_grant itself) to the highest (last_grant+1). Each valid
    // candidate overrides the previous one, so the last override is the
    // first valid requester after last_grant.
    always_comb begin
        grant_s       = last_grant_r;
        grant_found_s = 1'b0;
        cand_s        = last_grant_r;
        for (int k = NREQ; k >= 1; k--) begin
            cand_s        = GW'((int'(last_grant_r) + k) % NREQ);
            grant_s       = req_valid[cand_s] ? cand_s : grant_s;
            grant_found_s = grant_found_s | req_valid[cand_s];
        end
    end

    // One-hot handshake decode: ready only in IDLE, valid only in RESP.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        rsp_valid_s = {NREQ{1'b0}};
        if ((state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
        if (state_r == ST_RESP) begin
            rsp_valid_s[last_grant_r] = 1'b1;
        end else begin
            rsp_valid_s = {NREQ{1'b0}};
        end
    end

    // The response is consumed only by the requester that owns it.
    always_comb begin
        rsp_accept_s = 1'b0;
        if (state_r == ST_RESP) begin
            rsp_accept_s = rsp_ready[last_grant_r];
        end else begin
            rsp_accept_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = grant_found_s ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = rsp_accept_s ? ST_IDLE : ST_RESP;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant capture: the operands and the owner are loaded only on accept.
    // Otherwise they hold, so the core inputs stay quiet between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= GW'(NREQ - 1);
            core_a_r     <= 8'd0;
            core_b_r     <= 8'd0;
        end else if ((state_r == ST_IDLE) && grant_found_s) begin
            last_grant_r <= grant_s;
            core_a_r     <= req_a[32'(grant_s) * 32'd8 +: 8];
            core_b_r     <= req_b[32'(grant_s) * 32'd8 +: 8];
        end
    end

    // Result capture at the end of the EXEC cycle. The value is held until
    // the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum_r <= 9'd0;
        end else if (state_r == ST_EXEC) begin
            rsp_sum_r <= core_o;
        end
    end

    // Completed-response counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= {CNTW{1'b0}};
        end else if (rsp_accept_s && (op_count_r != {CNTW{1'b1}})) begin
            op_count_r <= op_count_r + CNTW'(1);
        end
    end

    // req_ready is masked by reset, so no accept is signalled while reset
    // is held, even if a requester is already valid.
    assign req_ready = req_ready_s & {NREQ{rst_n}};
    assign rsp_valid = rsp_valid_s;
    assign rsp_sum   = rsp_sum_r;
    assign core_a    = core_a_r;
    assign core_b    = core_b_r;
    assign busy      = (state_r != ST_IDLE);
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_add8u_share_sched.sv
module tb_add8u_share_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b;
    logic [8:0]  rsp_sum, core_o;
    logic [7:0]  core_a, core_b;
    logic        busy;
    logic [15:0] op_count;

    logic [3:0]  s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [31:0] s_req_a, s_req_b;
    logic [8:0]  s_rsp_sum, s_core_o;
    logic [7:0]  s_core_a, s_core_b;
    logic        s_busy;
    logic [1:0]  s_op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Exact bench adder cores.
    assign core_o   = {1'b0, core_a} + {1'b0, core_b};
    assign s_core_o = {1'b0, s_core_a} + {1'b0, s_core_b};

    add8u_share_sched #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .core_a(core_a), .core_b(core_b), .core_o(core_o),
        .busy(busy), .op_count(op_count)
    );

    add8u_share_sched #(.NREQ(4), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_sum(s_rsp_sum), .core_a(s_core_a), .core_b(s_core_b), .core_o(s_core_o),
        .busy(s_busy), .op_count(s_op_count)
    );

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        settle();
        exp_cnt = 0;
    endtask

    // One isolated op: accept in cycle 0, response in cycle 2, done in cycle 3.
    task automatic single_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [8:0] s);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_valid = 4'b0001 << idx;
        rsp_ready = 4'b0000;
        settle();
        chk("op_ready", req_ready, 32'(4'b0001 << idx));
        chk("op_idle_busy", busy, 32'd0);
        tick();
        req_valid = 4'b0000;
        settle();
        chk("op_exec_busy", busy, 32'd1);
        chk("op_core_a", core_a, a);
        chk("op_core_b", core_b, b);
        chk("op_exec_rspv", rsp_valid, 32'd0);
        tick();
        chk("op_rsp_valid", rsp_valid, 32'(4'b0001 << idx));
        chk("op_rsp_sum", rsp_sum, s);
        rsp_ready = 4'b0001 << idx;
        tick();
        rsp_ready = 4'b0000;
        exp_cnt++;
        settle();
        chk("op_done_busy", busy, 32'd0);
        chk("op_done_rspv", rsp_valid, 32'd0);
        chk("op_count", op_count, exp_cnt);
    endtask

    initial begin
        vec_t       tbl[5];
        int         sat_seq[5];
        logic [7:0] ra[4];
        logic [7:0] rb[4];
        logic [3:0] pend;
        logic [3:0] er, ev;
        int         m_phase, m_owner, m_last, m_cnt, g;
        logic [7:0] m_a, m_b;
        logic [8:0] m_sum;

        tbl[0] = '{0, 8'd200, 8'd100, 9'd300};
        tbl[1] = '{1, 8'd255, 8'd255, 9'd510};
        tbl[2] = '{2, 8'd0,   8'd0,   9'd0};
        tbl[3] = '{3, 8'd128, 8'd127, 9'd255};
        tbl[4] = '{1, 8'd7,   8'd9,   9'd16};
        sat_seq = '{1, 2, 3, 3, 3};

        req_valid = 4'h0; rsp_ready = 4'h0; req_a = 32'h0; req_b = 32'h0;
        s_req_valid = 4'h0; s_rsp_ready = 4'hF; s_req_a = 32'd1; s_req_b = 32'd2;

        // Reset state.
        #2;
        chk("rst_req_ready", req_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_sum", rsp_sum, 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_core_b", core_b, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        tick();
        rst_n = 1'b1;
        settle();

        // Table-driven single ops.
        for (int i = 0; i < 5; i++) begin
            single_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].sum);
        end

        // Operand hold while idle.
        single_op(0, 8'd7, 8'd9, 9'd16);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_core_a", core_a, 32'd7);
            chk("hold_core_b", core_b, 32'd9);
            chk("hold_busy", busy, 32'd0);
        end

        // Round-robin with all valid.
        do_reset();
        req_a = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b = {8'd10, 8'd10, 8'd10, 8'd10};
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_grant", req_ready, 32'(4'b0001 << (k % 4)));
            tick();
            tick();
            chk("rr_rsp_valid", rsp_valid, 32'(4'b0001 << (k % 4)));
            chk("rr_rsp_sum", rsp_sum, 32'(10 + (k % 4)));
            tick();
            exp_cnt++;
        end
        req_valid = 4'h0;
        rsp_ready = 4'h0;
        settle();
        chk("rr_count", op_count, exp_cnt);

        // Backpressure on requester 2, requester 1 waiting.
        req_a[23:16] = 8'd255; req_b[23:16] = 8'd255;
        req_a[15:8]  = 8'd20;  req_b[15:8]  = 8'd30;
        req_valid = 4'b0100;
        settle();
        chk("bp_grant", req_ready, 32'b0100);
        tick();
        req_valid = 4'b0010;
        settle();
        chk("bp_exec_ready", req_ready, 32'd0);
        tick();
        rsp_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_rsp_valid", rsp_valid, 32'b0100);
            chk("bp_rsp_sum", rsp_sum, 32'd510);
            chk("bp_req_ready", req_ready, 32'd0);
            chk("bp_count_hold", op_count, exp_cnt);
            tick();
        end
        rsp_ready = 4'b0100;
        settle();
        chk("bp_rsp_valid_last", rsp_valid, 32'b0100);
        tick();
        rsp_ready = 4'b0000;
        exp_cnt++;
        settle();
        chk("bp_count_inc", op_count, exp_cnt);
        chk("bp_waiter_grant", req_ready, 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("bp_waiter_sum", rsp_sum, 32'd50);
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
        exp_cnt++;

        // Reset during EXEC.
        req_a[31:24] = 8'd1; req_b[31:24] = 8'd2;
        req_valid = 4'b1000;
        settle();
        tick();
        req_valid = 4'b0000;
        settle();
        chk("mid_exec_busy", busy, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_req_ready", req_ready, 32'd0);
        chk("mid_rsp_valid", rsp_valid, 32'd0);
        chk("mid_rsp_sum", rsp_sum, 32'd0);
        chk("mid_core_a", core_a, 32'd0);
        chk("mid_core_b", core_b, 32'd0);
        chk("mid_busy", busy, 32'd0);
        chk("mid_op_count", op_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mid_post_rspv", rsp_valid, 32'd0);
            chk("mid_post_busy", busy, 32'd0);
            tick();
        end
        req_a = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b = {8'd10, 8'd10, 8'd10, 8'd10};
        req_valid = 4'hF;
        settle();
        chk("mid_first_grant", req_ready, 32'b0001);
        tick();
        req_valid = 4'h0;
        tick();
        rsp_ready = 4'hF;
        tick();
        rsp_ready = 4'h0;

        // Saturation with a 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            s_req_valid = 4'b0001;
            settle();
            chk("sat_ready", s_req_ready, 32'b0001);
            tick();
            s_req_valid = 4'b0000;
            chk("sat_core_a", s_core_a, 32'd1);
            tick();
            chk("sat_rsp_valid", s_rsp_valid, 32'b0001);
            chk("sat_rsp_sum", s_rsp_sum, 32'd3);
            tick();
            settle();
            chk("sat_count", s_op_count, sat_seq[k]);
            chk("sat_busy", s_busy, 32'd0);
        end

        // Randomized traffic against a transaction-level reference model.
        do_reset();
        m_phase = 0; m_owner = 0; m_last = 3; m_cnt = 0;
        m_a = 8'd0; m_b = 8'd0; m_sum = 9'd0;
        pend = 4'h0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'd0;
            rb[i] = 8'd0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && ($urandom_range(0, 7) == 0)) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    ra[i] = 8'($urandom_range(0, 255));
                    rb[i] = 8'($urandom_range(0, 255));
                end
            end
            req_valid = pend;
            req_a = {ra[3], ra[2], ra[1], ra[0]};
            req_b = {rb[3], rb[2], rb[1], rb[0]};
            rsp_ready = 4'($urandom_range(0, 15));
            settle();

            er = 4'h0; ev = 4'h0; g = -1;
            if (m_phase == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if ((g < 0) && pend[(m_last + k) % 4]) g = (m_last + k) % 4;
                end
                if (g >= 0) er[g] = 1'b1;
            end
            if (m_phase == 2) ev[m_owner] = 1'b1;
            chk("rnd_req_ready", req_ready, er);
            chk("rnd_rsp_valid", rsp_valid, ev);
            chk("rnd_busy", busy, (m_phase != 0) ? 32'd1 : 32'd0);
            chk("rnd_count", op_count, m_cnt);
            if (m_phase == 2) chk("rnd_rsp_sum", rsp_sum, m_sum);
            if (m_phase != 0) begin
                chk("rnd_core_a", core_a, m_a);
                chk("rnd_core_b", core_b, m_b);
            end

            if (m_phase == 0) begin
                if (g >= 0) begin
                    m_owner = g; m_last = g;
                    m_a = ra[g]; m_b = rb[g];
                    m_sum = {1'b0, ra[g]} + {1'b0, rb[g]};
                    pend[g] = 1'b0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (rsp_ready[m_owner]) begin
                m_phase = 0;
                if (m_cnt < 65535) m_cnt++;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add8u_share_sched.md
Name: add8u_share_sched

Overview:
- Round-robin scheduler that time-shares one combinational 8-bit unsigned adder core (9-bit result) among NREQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block registers the operands and holds them stable on the core across the evaluation cycle, then registers the core result.
- It sits between the requesting datapaths and a single approximate adder instance. The inputs are held between ops to cut switching power.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNTW, 16, width of the saturating completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept, one-hot or zero.
- req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing as req_a.
- rsp_valid  out  NREQ  per-requester response valid, one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_sum  out  9  result, shared by all requesters, qualified by rsp_valid.
- core_a  out  8  operand A to the adder core.
- core_b  out  8  operand B to the adder core.
- core_o  in  9  adder core result (combinational from core_a/core_b).
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNTW  completed responses, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0) clears the following:
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_sum=0, core_a=0, core_b=0, busy=0, op_count=0.
  - last_grant=NREQ-1, so requester 0 has highest priority first.
  - Reset mid-operation discards the pending op. No response is issued for it.
- States: IDLE, EXEC, RESP (2-bit encoding).
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: capture req_a[g]/req_b[g] into core_a/core_b, set last_grant=g, go to EXEC.
  - No req_valid: stay in IDLE; core_a/core_b keep their last values (no toggling).
- EXEC:
  - Exactly one cycle. core_a/core_b are stable registers.
  - At the end of the cycle, rsp_sum<=core_o; go to RESP.
- RESP:
  - rsp_valid[last_grant]=1.
  - rsp_sum holds until the edge where rsp_ready[last_grant]=1. On that edge: go to IDLE and increment op_count (saturating at 2^CNTW-1).
  - rsp_ready on other indices is ignored.
- Timing:
  - Latency from request accept to rsp_valid is 2 cycles.
  - Minimum of 3 cycles per op; no new request is accepted in EXEC or RESP.
- Protocol:
  - A requester must hold req_valid and its operands until req_ready. A drop before ready is legal and simply removes the request from arbitration.
  - req_ready is asserted only in IDLE.
  - Requests asserted during EXEC/RESP wait; they are not lost.
- Fairness:
  - The requester just served has the lowest priority at the next arbitration.
  - With all requesters valid, grant order is 0,1,..,NREQ-1,0,...
- Width rules:
  - rsp_sum is the full 9-bit core result, passed unmodified (approximation errors come from the core).
  - The block performs no arithmetic on the data path.
- Unused upper bits of the one-hot vectors never assert.
- busy=1 in EXEC and RESP.

Test Plan:
- Single request. Bench core is exact (core_o=core_a+core_b).
  - Stimulus: reset; req_valid=0001, A0=200, B0=100.
  - Response: req_ready=0001 in cycle 0; rsp_valid=0001 with rsp_sum=300 in cycle 2; rsp_ready=1 → IDLE in cycle 3; op_count=1.
- Round-robin.
  - Stimulus: all four valid continuously, A_i=i, B_i=10; rsp_ready tied 1.
  - Response: grants 0,1,2,3,0 at 3-cycle spacing; sums 10,11,12,13,10.
- Backpressure.
  - Stimulus: requester 2 request, A=255, B=255; rsp_ready low for 5 cycles.
  - Response: rsp_valid=0100 held; rsp_sum=510 stable; req_ready stays 0 for a waiting requester 1; op_count increments only once, on rsp_ready.
- Operand hold.
  - Stimulus: after one op with A=7, B=9, idle 10 cycles with req_valid=0.
  - Response: core_a=7 and core_b=9 unchanged throughout; busy=0.
- Reset mid-op.
  - Stimulus: rst_n asserted low during EXEC.
  - Response: all outputs zero immediately (asynchronous); no rsp_valid after release; the next grant goes to requester 0.
- Saturation.
  - Stimulus: CNTW=2, 5 completed ops.
  - Response: op_count sequence 1,2,3,3,3.
